// File: rtl/prm_edge_pkg.sv
// Shared types and helpers for the PRM edge-mask engine.
package prm_edge_pkg;
  localparam int IDX_W_DEF = 8;
  localparam int EDGES_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {INIT, IDLE, ACCUM, DRAIN, OUT} state_e;

  // Increment saturating at 2**w-1 (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] max;
    max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction
endpackage

// File: rtl/prm_edge_mask_engine_if.sv
// Config, obstacle-stream and result bundle for the edge-mask engine.
interface prm_edge_mask_engine_if #(
  parameter int IDX_W = 8,
  parameter int EDGES = 32,
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [EDGES-1:0] cfg_data;
  logic             cfg_ready;
  logic             s_valid;
  logic [IDX_W-1:0] s_idx;
  logic             s_last;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic [EDGES-1:0] edge_mask;
  logic [CNT_W-1:0] hit_count;
  logic             busy;

  modport master (
    output cfg_we, cfg_addr, cfg_data, s_valid, s_idx, s_last, m_ready,
    input  cfg_ready, s_ready, m_valid, edge_mask, hit_count, busy
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, s_valid, s_idx, s_last, m_ready,
    output cfg_ready, s_ready, m_valid, edge_mask, hit_count, busy
  );
endinterface

// File: rtl/prm_edge_lut.sv
// Voxel -> edge-blocking word table: 1R1W, synchronous read, no reset.
module prm_edge_lut #(
  parameter int IDX_W = 8,
  parameter int EDGES = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [EDGES-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [EDGES-1:0] rdata
);
  logic [EDGES-1:0] mem [2**IDX_W];
  logic [EDGES-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/prm_edge_mask_engine.sv
// Streams obstacle voxel indices through the LUT and ORs the per-edge words
// into one mask per frame, with a saturating count of blocking voxels.
module prm_edge_mask_engine
  import prm_edge_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int EDGES = EDGES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  prm_edge_mask_engine_if.slave bus
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             rd_vld_q, rd_vld_d;
  logic [EDGES-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             lut_we;
  logic [IDX_W-1:0] lut_waddr;
  logic [EDGES-1:0] lut_wdata;
  logic [EDGES-1:0] lut_rdata;
  logic             cfg_ready, s_ready, s_fire;

  prm_edge_lut #(.IDX_W(IDX_W), .EDGES(EDGES)) u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .re    (s_fire),
    .raddr (bus.s_idx),
    .rdata (lut_rdata)
  );

  assign s_fire = bus.s_valid & s_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rd_vld_d  = s_fire;
    lut_we    = 1'b0;
    lut_waddr = ptr_q;
    lut_wdata = '0;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;

    // Second pipeline stage: the word read last cycle lands in the accumulator.
    if (rd_vld_q) begin
      acc_d = acc_q | lut_rdata;
      if (lut_rdata != '0) cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end

    case (state_q)
      INIT: begin
        lut_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == {IDX_W{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        cfg_ready = 1'b1;
        s_ready   = !bus.cfg_we;
        if (bus.cfg_we) begin
          lut_we    = 1'b1;
          lut_waddr = bus.cfg_addr;
          lut_wdata = bus.cfg_data;
        end
        if (s_fire) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = bus.s_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        s_ready = 1'b1;
        if (s_fire && bus.s_last) state_d = DRAIN;
      end
      DRAIN: if (!rd_vld_q) state_d = OUT;
      OUT:   if (bus.m_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      rd_vld_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_vld_q <= rd_vld_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = (state_q == OUT);
  assign bus.edge_mask = acc_q;
  assign bus.hit_count = cnt_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Directed bench for prm_edge_mask_engine: init sweep, LUT config, frame results, backpressure, reset abort, saturation.
module tb_prm_edge_mask_engine;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  prm_edge_mask_engine_if #(.IDX_W(8), .EDGES(32), .CNT_W(16)) bus ();

  prm_edge_mask_engine #(.IDX_W(8), .EDGES(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] idx, input logic last);
    int w;
    bus.s_valid = 1'b1;
    bus.s_idx   = idx;
    bus.s_last  = last;
    #0;
    w = 0;
    while (!bus.s_ready && w < 100) begin
      tick;
      w++;
    end
    if (w >= 100) chk("beat_timeout", 64'd1, 64'd0);
    tick;
  endtask

  task automatic end_frame;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
    chk("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick;
    bus.cfg_we = 1'b0;
  endtask

  task automatic wait_mvalid(input string tag);
    int w;
    w = 0;
    while (!bus.m_valid && w < 100) begin
      tick;
      w++;
    end
    if (w >= 100) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic result(input string tag, input logic [31:0] mask, input logic [15:0] hit);
    wait_mvalid(tag);
    chk({tag, "_mask"}, 64'(bus.edge_mask), 64'(mask));
    chk({tag, "_hit"},  64'(bus.hit_count), 64'(hit));
    bus.m_ready = 1'b1;
    tick;
    bus.m_ready = 1'b0;
    chk({tag, "_mvalid_drop"}, 64'(bus.m_valid), 64'd0);
    tick;
  endtask

  // Counts cycles spent busy after reset release; flags any result leaking out.
  task automatic init_sweep(input string tag);
    int n;
    logic seen_mv, seen_cfg;
    n = 0; seen_mv = 1'b0; seen_cfg = 1'b0;
    while (bus.busy && n < 1000) begin
      if (bus.m_valid)   seen_mv  = 1'b1;
      if (bus.cfg_ready) seen_cfg = 1'b1;
      tick;
      n++;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd256);
    chk({tag, "_no_mvalid"},   64'(seen_mv), 64'd0);
    chk({tag, "_no_cfg_ready"}, 64'(seen_cfg), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.s_valid = 1'b0; bus.s_idx = '0; bus.s_last = 1'b0;
    bus.m_ready = 1'b0;
    tick;
    tick;

    // Reset state
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("rst_s_ready",   64'(bus.s_ready),   64'd0);
    chk("rst_m_valid",   64'(bus.m_valid),   64'd0);
    chk("rst_edge_mask", 64'(bus.edge_mask), 64'd0);
    chk("rst_hit_count", 64'(bus.hit_count), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd1);
    rst = 1'b0;

    // 1: init sweep length and zeroed LUT
    init_sweep("init");
    chk("idle_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    for (int i = 0; i < 256; i++) beat(8'(i), i == 255);
    end_frame;
    result("zero_lut", 32'h0, 16'd0);

    // 2: loaded entries, 3-beat frame, latency
    cfg_write(8'd3, 32'h0000_0011);
    cfg_write(8'd7, 32'h8000_0001);
    beat(8'd3, 1'b0);
    beat(8'd5, 1'b0);
    beat(8'd7, 1'b1);
    end_frame;
    lat = 1;
    while (!bus.m_valid && lat < 50) begin
      tick;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    result("frame357", 32'h8000_0011, 16'd2);

    // 3: single beat, result held under backpressure
    beat(8'd3, 1'b1);
    end_frame;
    wait_mvalid("hold");
    for (int i = 0; i < 10; i++) begin
      chk("hold_mvalid",  64'(bus.m_valid),   64'd1);
      chk("hold_mask",    64'(bus.edge_mask), 64'h11);
      chk("hold_s_ready", 64'(bus.s_ready),   64'd0);
      tick;
    end
    result("single", 32'h0000_0011, 16'd1);

    // 4a: cfg write wins over a beat in IDLE
    bus.cfg_we = 1'b1; bus.cfg_addr = 8'd5; bus.cfg_data = 32'h0000_0100;
    bus.s_valid = 1'b1; bus.s_idx = 8'd5; bus.s_last = 1'b1;
    #1;
    chk("cfg_prio_s_ready", 64'(bus.s_ready), 64'd0);
    tick;
    chk("cfg_prio_not_accepted", 64'(bus.busy), 64'd0);
    bus.cfg_we = 1'b0;
    beat(8'd5, 1'b1);
    end_frame;
    result("cfg_prio", 32'h0000_0100, 16'd1);

    // 4b: cfg write during ACCUM is ignored
    beat(8'd3, 1'b0);
    bus.cfg_we = 1'b1; bus.cfg_addr = 8'd9; bus.cfg_data = 32'hFFFF_FFFF;
    #1;
    chk("accum_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    beat(8'd7, 1'b1);
    bus.cfg_we = 1'b0;
    end_frame;
    result("accum_cfg", 32'h8000_0011, 16'd2);
    beat(8'd9, 1'b1);
    end_frame;
    result("lut9_unchanged", 32'h0, 16'd0);

    // 5: reset mid-frame aborts and re-zeroes the LUT
    beat(8'd3, 1'b0);
    beat(8'd7, 1'b0);
    end_frame;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    init_sweep("abort");
    for (int i = 0; i < 5; i++) begin
      chk("abort_idle_mvalid", 64'(bus.m_valid), 64'd0);
      tick;
    end
    beat(8'd3, 1'b1);
    end_frame;
    result("post_reset", 32'h0, 16'd0);

    // 6: hit counter saturation
    cfg_write(8'd3, 32'h0000_0011);
    for (int i = 0; i < 70000; i++) beat(8'd3, i == 69999);
    end_frame;
    result("saturate", 32'h0000_0011, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
